// File: rtl/bcd_tick_pkg.sv
// Shared definitions for the two-digit BCD tick counter.
// Holds the FSM state encoding, the active-high 7-segment patterns,
// and a helper that checks whether a nibble is a legal BCD digit.
package bcd_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high form
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // True when the nibble holds a decimal digit 0..9
    function automatic logic bcd_digit_ok(input logic [3:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Decodes one BCD digit into a 7-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal codes blank the digit. SEG_ACTIVE_LOW inverts the pattern
// for common-anode displays.
module bcd_to_seg7
    import bcd_tick_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    logic [6:0] w_pattern;

    // Look up the active-high pattern for the digit
    always_comb begin
        w_pattern = SEG_BLANK;
        case (i_digit)
            4'd0:    w_pattern = SEG_0;
            4'd1:    w_pattern = SEG_1;
            4'd2:    w_pattern = SEG_2;
            4'd3:    w_pattern = SEG_3;
            4'd4:    w_pattern = SEG_4;
            4'd5:    w_pattern = SEG_5;
            4'd6:    w_pattern = SEG_6;
            4'd7:    w_pattern = SEG_7;
            4'd8:    w_pattern = SEG_8;
            4'd9:    w_pattern = SEG_9;
            default: w_pattern = SEG_BLANK;
        endcase
    end

    // Apply the display polarity
    always_comb begin
        if (SEG_ACTIVE_LOW) begin
            o_seg = ~w_pattern;
        end else begin
            o_seg = w_pattern;
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter advanced by rising edges of a slow
// divided clock (tick_in) that is sampled as a level in the clk domain.
// An IDLE/RUN/PAUSE FSM gates counting; load forces a value and IDLE.
// Both digits are decoded to 7-segment patterns for the board display.
module bcd_tick_counter
    import bcd_tick_pkg::*;
#(
    parameter logic [7:0] MAX_COUNT      = 8'h59,
    parameter bit         SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start,
    input  logic       pause,
    input  logic       up_dn,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       tc,
    output logic       running,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones
);

    state_t     r_state;
    logic       r_tick_d;
    logic [7:0] r_count;
    logic       r_tc;
    logic       r_running;

    logic       w_tick_rise;
    logic       w_load_ok;
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    logic [7:0] w_count_step;
    logic       w_wrap;

    assign w_tick_rise = tick_in & ~r_tick_d;
    assign w_tens      = r_count[7:4];
    assign w_ones      = r_count[3:0];

    // A load value is accepted only if it is proper BCD and within the wrap limit
    always_comb begin
        if (bcd_digit_ok(load_val[7:4]) && bcd_digit_ok(load_val[3:0]) &&
            (load_val <= MAX_COUNT)) begin
            w_load_ok = 1'b1;
        end else begin
            w_load_ok = 1'b0;
        end
    end

    // Next BCD value for one counted tick, with wrap detection in both directions
    always_comb begin
        w_count_step = r_count;
        w_wrap       = 1'b0;
        if (up_dn) begin
            if (r_count == MAX_COUNT) begin
                w_count_step = 8'h00;
                w_wrap       = 1'b1;
            end else if (w_ones == 4'd9) begin
                w_count_step = {w_tens + 4'd1, 4'd0};
            end else begin
                w_count_step = {w_tens, w_ones + 4'd1};
            end
        end else begin
            if (r_count == 8'h00) begin
                w_count_step = MAX_COUNT;
                w_wrap       = 1'b1;
            end else if (w_ones == 4'd0) begin
                w_count_step = {w_tens - 4'd1, 4'd9};
            end else begin
                w_count_step = {w_tens, w_ones - 4'd1};
            end
        end
    end

    // FSM, edge detector, count register and registered tc/running flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_tick_d  <= 1'b0;
            r_count   <= 8'h00;
            r_tc      <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_tick_d <= tick_in;
            if (load) begin
                // Load overrides everything; a coincident tick is discarded
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
                r_count   <= w_load_ok ? load_val : 8'h00;
                r_tc      <= 1'b0;
            end else begin
                // A tick seen while in RUN counts even if pause arrives on the same edge
                if ((r_state == ST_RUN) && w_tick_rise) begin
                    r_count <= w_count_step;
                    r_tc    <= w_wrap;
                end else begin
                    r_tc    <= 1'b0;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (pause) begin
                            r_state   <= ST_IDLE;
                            r_running <= 1'b0;
                        end else if (start) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_running <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end else begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (pause) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end else if (start) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign running = r_running;

    bcd_to_seg7 #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg_tens (
        .i_digit(r_count[7:4]),
        .o_seg  (seg_tens)
    );

    bcd_to_seg7 #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg_ones (
        .i_digit(r_count[3:0]),
        .o_seg  (seg_ones)
    );

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter (MAX_COUNT=8'h59, active-low segments).
// Expected counts are pushed to a queue as each tick/load is driven and
// popped when the DUT result is sampled on the following falling edge.
module tb_bcd_tick_counter;

    logic       clk;
    logic       rst;
    logic       tick_in;
    logic       start;
    logic       pause;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc;
    logic       running;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;

    int         n_checks;
    int         n_errors;
    logic [7:0] exp_q[$];

    bcd_tick_counter #(
        .MAX_COUNT     (8'h59),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .start   (start),
        .pause   (pause),
        .up_dn   (up_dn),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .tc      (tc),
        .running (running),
        .seg_tens(seg_tens),
        .seg_ones(seg_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise tick_in for 'hold' clocks; report count one edge after the rise,
    // count at the end of the hold, and how many sampled cycles showed tc high.
    task automatic drive_tick(input int hold, output logic [7:0] obs,
                              output logic [7:0] obs_end, output int tc_n);
        tc_n = 0;
        @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        obs = count;
        if (tc) tc_n++;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            if (tc) tc_n++;
        end
        obs_end = count;
        tick_in = 1'b0;
        @(negedge clk);
        if (tc) tc_n++;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (count !== 8'h00) begin n_errors++; $display("FAIL reset_count got %h want 00", count); end
        n_checks++;
        if (running !== 1'b0 || tc !== 1'b0) begin n_errors++; $display("FAIL reset_flags got run=%b tc=%b want 0 0", running, tc); end
        n_checks++;
        if (seg_tens !== 7'b1000000 || seg_ones !== 7'b1000000) begin
            n_errors++; $display("FAIL reset_seg got %b %b want 1000000 1000000", seg_tens, seg_ones);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        logic [7:0] obs, obs_end, e;
        int         tc_n;
        up_dn = 1'b1;
        pulse_start();
        n_checks++;
        if (running !== 1'b1) begin n_errors++; $display("FAIL start_running got %b want 1", running); end
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(8'(k));
            drive_tick(4, obs, obs_end, tc_n);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e || obs_end !== e) begin n_errors++; $display("FAIL up_tick%0d got %h/%h want %h", k, obs, obs_end, e); end
            n_checks++;
            if (tc_n !== 0) begin n_errors++; $display("FAIL up_tc%0d got %0d pulses want 0", k, tc_n); end
        end
        n_checks++;
        if (running !== 1'b1) begin n_errors++; $display("FAIL up_running got %b want 1", running); end
    endtask

    task automatic test_wrap_up();
        logic [7:0] obs, obs_end, e;
        int         tc_n;
        exp_q.push_back(8'h58);
        do_load(8'h58);
        e = exp_q.pop_front();
        n_checks++;
        if (count !== e || running !== 1'b0) begin n_errors++; $display("FAIL wrap_load got %h run=%b want %h run=0", count, running, e); end
        pulse_start();
        up_dn = 1'b1;
        exp_q.push_back(8'h59);
        drive_tick(3, obs, obs_end, tc_n);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || tc_n !== 0) begin n_errors++; $display("FAIL wrap_59 got %h tc=%0d want %h tc=0", obs, tc_n, e); end
        exp_q.push_back(8'h00);
        drive_tick(3, obs, obs_end, tc_n);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL wrap_00 got %h want %h", obs, e); end
        n_checks++;
        if (tc_n !== 1) begin n_errors++; $display("FAIL wrap_tc got %0d pulses want 1", tc_n); end
    endtask

    task automatic test_wrap_down();
        logic [7:0] obs, obs_end, e;
        int         tc_n;
        up_dn = 1'b0;
        exp_q.push_back(8'h59);
        drive_tick(2, obs, obs_end, tc_n);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || tc_n !== 1) begin n_errors++; $display("FAIL down_wrap got %h tc=%0d want %h tc=1", obs, tc_n, e); end
        exp_q.push_back(8'h58);
        drive_tick(2, obs, obs_end, tc_n);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || tc_n !== 0) begin n_errors++; $display("FAIL down_58 got %h tc=%0d want %h tc=0", obs, tc_n, e); end
        exp_q.push_back(8'h49);
        do_load(8'h50);
        pulse_start();
        drive_tick(2, obs, obs_end, tc_n);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || tc_n !== 0) begin n_errors++; $display("FAIL down_borrow got %h tc=%0d want %h tc=0", obs, tc_n, e); end
        do_load(8'h58);
        pulse_start();
    endtask

    task automatic test_hold_pause();
        logic [7:0] obs, obs_end, e;
        int         tc_n;
        up_dn = 1'b0;
        exp_q.push_back(8'h57);
        drive_tick(20, obs, obs_end, tc_n);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || obs_end !== e) begin n_errors++; $display("FAIL hold20 got %h/%h want %h", obs, obs_end, e); end
        // pause together with a rising tick
        exp_q.push_back(8'h56);
        @(negedge clk);
        pause   = 1'b1;
        tick_in = 1'b1;
        @(negedge clk);
        pause   = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (count !== e || running !== 1'b0) begin n_errors++; $display("FAIL pause_tick got %h run=%b want %h run=0", count, running, e); end
        tick_in = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(8'h56);
            drive_tick(3, obs, obs_end, tc_n);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_end !== e) begin n_errors++; $display("FAIL paused_drop%0d got %h want %h", k, obs_end, e); end
        end
        pulse_start();
        exp_q.push_back(8'h55);
        drive_tick(2, obs, obs_end, tc_n);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || running !== 1'b1) begin n_errors++; $display("FAIL resume got %h run=%b want %h run=1", obs, running, e); end
    endtask

    task automatic test_load();
        logic [7:0] vals[6];
        logic [7:0] exps[6];
        logic [7:0] e;
        vals = '{8'h6A, 8'h75, 8'h59, 8'h60, 8'h09, 8'h42};
        exps = '{8'h00, 8'h00, 8'h59, 8'h00, 8'h09, 8'h42};
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(exps[k]);
            do_load(vals[k]);
            e = exp_q.pop_front();
            n_checks++;
            if (count !== e || running !== 1'b0) begin
                n_errors++; $display("FAIL load_%h got %h run=%b want %h run=0", vals[k], count, running, e);
            end
        end
        n_checks++;
        if (seg_tens !== 7'b0011001 || seg_ones !== 7'b0100100) begin
            n_errors++; $display("FAIL seg_42 got %b %b want 0011001 0100100", seg_tens, seg_ones);
        end
        // load with a coincident tick while running: tick discarded
        pulse_start();
        exp_q.push_back(8'h12);
        @(negedge clk);
        load     = 1'b1;
        load_val = 8'h12;
        tick_in  = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        tick_in  = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (count !== e || running !== 1'b0 || tc !== 1'b0) begin
            n_errors++; $display("FAIL load_tick got %h run=%b tc=%b want %h run=0 tc=0", count, running, tc, e);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] obs, obs_end, e;
        int         tc_n;
        up_dn = 1'b1;
        pulse_start();
        drive_tick(2, obs, obs_end, tc_n);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 8'h00 || running !== 1'b0) begin n_errors++; $display("FAIL async_rst got %h run=%b want 00 run=0", count, running); end
        n_checks++;
        if (seg_ones !== 7'b1000000) begin n_errors++; $display("FAIL async_rst_seg got %b want 1000000", seg_ones); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(8'h00);
        drive_tick(2, obs, obs_end, tc_n);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || running !== 1'b0) begin n_errors++; $display("FAIL post_rst_idle got %h run=%b want %h run=0", obs, running, e); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        tick_in  = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_hold_pause();
        test_load();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
